// File: rtl/psum_drain_buffer_pkg.sv
// Shared configuration for the systolic-array output collector.
// Holds the default geometry and the partial-sum row types.
package psum_drain_buffer_pkg;

    parameter int sys_cols         = 2;
    parameter int p_bitwidth       = 24;
    parameter int out_buffer_depth = 16;
    parameter int tile_rows_w      = 8;

    typedef logic [p_bitwidth-1:0] psum_t;
    typedef psum_t [sys_cols-1:0]  psum_row_t;

    // Column c arrives c cycles after column 0, so it needs the complementary delay.
    function automatic int skew_delay(input int col, input int cols);
        return cols - 1 - col;
    endfunction

endpackage

// File: rtl/psum_drain_buffer_if.sv
// Aligned-row drain stream from the collector to the writeback path.
interface psum_drain_buffer_if #(
    parameter int SYS_COLS   = 2,
    parameter int P_BITWIDTH = 24
);
    logic                           out_valid;
    logic                           out_ready;
    logic [SYS_COLS*P_BITWIDTH-1:0] out_row;
    logic                           out_last;

    modport master (
        output out_valid,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_row,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/psum_drain_buffer_sync_fifo.sv
// Row storage FIFO: array storage, registered read data that always shows the head
// row, and full/empty/count status. Read data holds its value while empty.
module psum_drain_buffer_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] rd_data_reg;
    logic             do_wr, do_rd;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign rd_data = rd_data_reg;
    assign count   = count_reg;

    always_comb begin
        do_rd       = rd_en && !empty && !flush;
        do_wr       = wr_en && (!full || do_rd) && !flush;
        rd_ptr_next = do_rd ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // Prefetch the next head; a write into an empty slot is forwarded directly.
            if (count_next != '0) begin
                rd_data_reg <= (do_wr && (wr_ptr_reg == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
            end
        end
    end
endmodule

// File: rtl/psum_drain_buffer.sv
// Deskews the per-column partial-sum streams into aligned rows, buffers them,
// drains them with tile framing and stalls the array before the buffer fills.
module psum_drain_buffer
    import psum_drain_buffer_pkg::*;
#(
    parameter int SYS_COLS   = sys_cols,
    parameter int P_BITWIDTH = p_bitwidth,
    parameter int DEPTH      = out_buffer_depth,
    parameter int ROWS_W     = tile_rows_w
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SYS_COLS-1:0]            col_valid,
    input  logic [SYS_COLS*P_BITWIDTH-1:0] col_psum,
    output logic                           array_stall,
    input  logic                           tile_start,
    input  logic [ROWS_W-1:0]              tile_rows,
    input  logic                           flush,
    psum_drain_buffer_if.master            out_bus,
    output logic                           tile_done,
    output logic                           overflow_err,
    output logic                           skew_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - SYS_COLS);

    logic [SYS_COLS-1:0]            dly_valid;
    logic [SYS_COLS*P_BITWIDTH-1:0] dly_row;
    logic                           aligned_valid, skew_hit, overflow_hit, beat_rd, beat_acc, is_last;
    logic [SYS_COLS*P_BITWIDTH-1:0] fifo_rd_data;
    logic                           fifo_full, fifo_empty;
    logic [CW-1:0]                  fifo_count;
    logic                           array_stall_reg, overflow_err_reg, skew_err_reg, tile_done_reg;
    logic [ROWS_W-1:0]              row_cnt_reg, tile_rows_q;

    for (genvar gi = 0; gi < SYS_COLS; gi++) begin : g_col
        localparam int DLY = skew_delay(gi, SYS_COLS);
        if (DLY == 0) begin : g_direct
            assign dly_valid[gi] = col_valid[gi];
            assign dly_row[gi*P_BITWIDTH +: P_BITWIDTH] = col_psum[gi*P_BITWIDTH +: P_BITWIDTH];
        end else begin : g_pipe
            logic [DLY-1:0]        v_pipe;
            logic [P_BITWIDTH-1:0] d_pipe [DLY];

            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    v_pipe <= '0;
                end else begin
                    v_pipe[0] <= col_valid[gi];
                    for (int k = 1; k < DLY; k++) begin
                        v_pipe[k] <= v_pipe[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                d_pipe[0] <= col_psum[gi*P_BITWIDTH +: P_BITWIDTH];
                for (int k = 1; k < DLY; k++) begin
                    d_pipe[k] <= d_pipe[k-1];
                end
            end

            assign dly_valid[gi] = v_pipe[DLY-1];
            assign dly_row[gi*P_BITWIDTH +: P_BITWIDTH] = d_pipe[DLY-1];
        end
    end

    assign aligned_valid = &dly_valid;
    assign skew_hit      = (|dly_valid) && !aligned_valid;
    assign beat_rd       = !fifo_empty && out_bus.out_ready;
    assign beat_acc      = beat_rd && !flush;
    assign overflow_hit  = aligned_valid && fifo_full && !beat_rd && !flush;
    assign is_last       = (row_cnt_reg == tile_rows_q - ROWS_W'(1));

    psum_drain_buffer_sync_fifo #(
        .WIDTH (SYS_COLS*P_BITWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (aligned_valid),
        .wr_data (dly_row),
        .rd_en   (out_bus.out_ready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            array_stall_reg  <= 1'b0;
            overflow_err_reg <= 1'b0;
            skew_err_reg     <= 1'b0;
        end else begin
            array_stall_reg <= (fifo_count >= STALL_AT);
            if (overflow_hit) overflow_err_reg <= 1'b1;
            if (skew_hit)     skew_err_reg     <= 1'b1;
        end
    end

    // A tile_start in the same cycle as a beat restarts the count and swallows that beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt_reg   <= '0;
            tile_rows_q   <= '0;
            tile_done_reg <= 1'b0;
        end else begin
            tile_done_reg <= 1'b0;
            if (tile_start) begin
                tile_rows_q <= tile_rows;
            end
            if (flush || tile_start) begin
                row_cnt_reg <= '0;
            end else if (beat_acc) begin
                if (is_last) begin
                    row_cnt_reg   <= '0;
                    tile_done_reg <= 1'b1;
                end else begin
                    row_cnt_reg <= row_cnt_reg + ROWS_W'(1);
                end
            end
        end
    end

    assign out_bus.out_valid = !fifo_empty;
    assign out_bus.out_row   = fifo_rd_data;
    assign out_bus.out_last  = !fifo_empty && is_last;
    assign array_stall       = array_stall_reg;
    assign overflow_err      = overflow_err_reg;
    assign skew_err          = skew_err_reg;
    assign tile_done         = tile_done_reg;
endmodule

// File: doc/psum_drain_buffer.md
# psum_drain_buffer

Output-side collector for the systolic array: the other end of the skewed data path that feeds activations in. Column c of the array emits each result row one cycle later than column c-1; this block deskews the SYS_COLS partial-sum streams back into aligned rows and buffers them in a FIFO. It drains the rows over a valid/ready stream to the writeback path, marks tile boundaries, and raises a stall to the array before the buffer can overflow.

## Interface
Parameters:
- SYS_COLS, default sys_cols (2): number of array columns / partial sums per row.
- P_BITWIDTH, default 24: partial-sum width.
- DEPTH, default 16: output buffer depth in rows; power of two, must be ≥ 2*SYS_COLS.
- ROWS_W, default 8: width of the tile row count.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: synchronous, active-low reset.
- col_valid, in, SYS_COLS: per-column result valid from the array bottom edge.
- col_psum, in, SYS_COLS×P_BITWIDTH: per-column partial sum; column c occupies bits [c*P_BITWIDTH +: P_BITWIDTH].
- array_stall, out, 1: upstream must stop issuing new rows from the next cycle.
- tile_start, in, 1: pulse; latches tile_rows and clears the row counter.
- tile_rows, in, ROWS_W: rows in the tile (1..2^ROWS_W-1).
- flush, in, 1: synchronous clear of the deskew pipe and FIFO.
- out_valid, out, 1: out_row holds a buffered row.
- out_ready, in, 1: consumer accepts the row.
- out_row, out, SYS_COLS×P_BITWIDTH: aligned row, same packing as col_psum.
- out_last, out, 1: the current beat is row tile_rows-1 of the tile.
- tile_done, out, 1: one-cycle pulse the cycle after the last beat is accepted.
- overflow_err, out, 1: sticky; set when an aligned row arrives while the FIFO is full.
- skew_err, out, 1: sticky; set when the deskewed valids disagree.

## Operation
- Deskew: column c passes through SYS_COLS-1-c registers (valid and data). Column SYS_COLS-1 has no delay. The aligned valid is the AND of all delayed valids.
- If the delayed valids are neither all 0 nor all 1, skew_err is set and no write occurs.
- FIFO write: an aligned row is written when aligned valid is high and the FIFO is not full. If the FIFO is full, the row is dropped and overflow_err is set.
- FIFO read: occurs on out_valid && out_ready. Simultaneous read and write is legal at any occupancy except full-without-read. Occupancy stays unchanged in that case.
- array_stall = (count ≥ DEPTH-SYS_COLS). This leaves room for the rows still in the deskew pipe plus one issued in the stall cycle.
- Row counter: increments on each accepted beat.
  - out_last = out_valid && (row_cnt == tile_rows_q-1).
  - When the last beat is accepted, row_cnt returns to 0 and tile_done pulses on the next cycle.
- tile_start: loads tile_rows_q and zeroes row_cnt. If it coincides with an accepted beat, tile_start wins and that beat is not counted. FIFO contents are untouched.
- flush: clears the deskew valids, FIFO pointers/count and row_cnt. Sticky errors are kept. A write or read in the same cycle is ignored.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- Data is passed through unmodified. There is no arithmetic on psums.

## Timing
- Reset values (rst_n low at a clk edge): array_stall 0, out_valid 0, out_row 0, out_last 0, tile_done 0, overflow_err 0, skew_err 0, count 0, row_cnt 0, tile_rows_q 0.
- Latency:
  - Column 0's element of a row enters at cycle T. Column SYS_COLS-1's element of the same row enters at T+SYS_COLS-1.
  - The aligned row is written at the end of cycle T+SYS_COLS-1.
  - out_valid rises at T+SYS_COLS if the FIFO was empty. There is no combinational bypass.
- out_row and out_last are stable while out_valid && !out_ready.
- Full FIFO: array_stall is already high and out_ready gates progress. Empty FIFO: out_valid is low and out_row holds the last value.
- array_stall is registered from count. It updates the cycle after count crosses the threshold.

## Structure
- Add to the Config package:
  - typedef psum_t = logic [P_BITWIDTH-1:0];
  - typedef psum_row_t = psum_t [sys_cols-1:0];
  - parameter out_buffer_depth = 16.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) holds the row storage: registered read data, full/empty/count. Deskew, stall, row counting and error logic stay in the top.

## Test plan
- Single row, SYS_COLS=2:
  - Stimulus: col0 = 0x000011 at cycle 0, col1 = 0x000022 at cycle 1, out_ready=1.
  - Required: out_valid at cycle 2, out_row = {0x000022, 0x000011}; with tile_rows=1, out_last=1 and tile_done at cycle 3.
- Tile of 4 rows streamed back-to-back with out_ready=1:
  - Required: four beats in order, out_last only on the 4th, one tile_done pulse.
- Backpressure with out_ready=0, rows streamed while honoring array_stall:
  - Required: array_stall rises when count reaches 14.
  - Required: no row lost, overflow_err stays 0, and all 16 rows drain in order afterwards.
- Forced overflow: ignore array_stall and push 17 rows with out_ready=0.
  - Required: overflow_err=1; the 16 stored rows are intact; the 17th is dropped.
- Skew fault: col1 valid with col0 invalid one cycle earlier.
  - Required: skew_err=1, no FIFO write.
- flush with 5 rows buffered mid-tile, then a new tile_start with tile_rows=2.
  - Required: out_valid=0 the next cycle, errors retained.
  - Required: the next two rows produce out_last on the second and one tile_done pulse.
